// File: rtl/tdc_event_arbiter_pkg.sv
// Shared TDC helpers: log2 sizing and event entry width.
// Entries are {channel, polarity, timestamp}.
package tdc_event_arbiter_pkg;

  function automatic int f_log2_size(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int f_ch_width(input int n);
    return (f_log2_size(n) < 1) ? 1 : f_log2_size(n);
  endfunction

  function automatic int f_entry_width(input int n, input int ts_w);
    return f_ch_width(n) + 1 + ts_w;
  endfunction

endpackage

// File: rtl/tdc_evfifo.sv
// Generic synchronous first-word-fall-through FIFO.
// Head reads as zero when empty; flush clears pointers only.
module tdc_evfifo
  import tdc_event_arbiter_pkg::*;
#(
  parameter int g_WIDTH = 8,
  parameter int g_DEPTH = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush,
  input  logic                             push,
  input  logic [g_WIDTH-1:0]               din,
  input  logic                             pop,
  output logic [g_WIDTH-1:0]               dout,
  output logic [f_log2_size(g_DEPTH):0]    level,
  output logic                             full,
  output logic                             empty
);

  localparam int AW = f_log2_size(g_DEPTH);
  localparam logic [AW:0] FULL_LVL = g_DEPTH[AW:0];

  logic [g_WIDTH-1:0] mem [g_DEPTH];
  logic [AW-1:0]      rd_ptr;
  logic [AW-1:0]      wr_ptr;
  logic [AW:0]        cnt;
  logic               do_pop;
  logic               do_push;

  assign empty   = (cnt == '0);
  assign full    = (cnt == FULL_LVL);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign level   = cnt;
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push & ~do_pop)      cnt <= cnt + 1'b1;
      else if (do_pop & ~do_push) cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push & ~flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/tdc_event_arbiter.sv
// Per-channel TDC event capture, round-robin grant into a shared
// FWFT FIFO, threshold interrupt and saturating drop counter.
module tdc_event_arbiter
  import tdc_event_arbiter_pkg::*;
#(
  parameter int g_CHANNEL_COUNT = 2,
  parameter int g_TS_WIDTH      = 38,
  parameter int g_FIFO_DEPTH    = 16,
  parameter int g_DROP_WIDTH    = 16
) (
  input  logic                                  wb_clk_i,
  input  logic                                  rst_n_i,
  input  logic [g_CHANNEL_COUNT-1:0]            enable_i,
  input  logic [g_CHANNEL_COUNT-1:0]            detect_i,
  input  logic [g_CHANNEL_COUNT-1:0]            polarity_i,
  input  logic [g_CHANNEL_COUNT*g_TS_WIDTH-1:0] ts_i,
  input  logic                                  flush_i,
  input  logic [f_log2_size(g_FIFO_DEPTH):0]    thresh_i,
  input  logic                                  rd_i,
  output logic                                  rd_valid_o,
  output logic [f_entry_width(g_CHANNEL_COUNT, g_TS_WIDTH)-1:0] rd_data_o,
  output logic [f_log2_size(g_FIFO_DEPTH):0]    level_o,
  output logic                                  irq_o,
  output logic [g_DROP_WIDTH-1:0]               drop_cnt_o
);

  localparam int N    = g_CHANNEL_COUNT;
  localparam int TSW  = g_TS_WIDTH;
  localparam int CH_W = f_ch_width(N);
  localparam int EW   = f_entry_width(N, TSW);
  localparam int DW   = g_DROP_WIDTH;
  localparam int DSW  = DW + 4;
  localparam logic [DW-1:0]   DROP_MAX = {DW{1'b1}};
  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(N - 1);

  logic [N-1:0]    hold_vld;
  logic [N-1:0]    hold_pol;
  logic [TSW-1:0]  hold_ts [N];
  logic [CH_W-1:0] rr_ptr;

  logic            fifo_full;
  logic            fifo_empty;
  logic            can_push;
  logic            gnt_vld;
  logic [CH_W-1:0] gnt_idx;
  logic [N-1:0]    load;
  logic [N-1:0]    drop;
  logic [DSW-1:0]  drop_sum;
  logic [DW-1:0]   drop_nxt;
  logic [EW-1:0]   gnt_entry;

  // A full FIFO still accepts a grant when the head leaves this cycle.
  assign can_push = ~fifo_full | (rd_i & ~fifo_empty);

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < N; i++) begin
      int k;
      k = (int'(rr_ptr) + i) % N;
      if (!gnt_vld && hold_vld[k]) begin
        gnt_vld = 1'b1;
        gnt_idx = CH_W'(k);
      end
    end
    if (!can_push) gnt_vld = 1'b0;
  end

  always_comb begin
    load = '0;
    drop = '0;
    for (int c = 0; c < N; c++) begin
      logic hit;
      logic gc;
      hit = detect_i[c] & enable_i[c];
      gc  = gnt_vld && (gnt_idx == CH_W'(c));
      load[c] = hit & (~hold_vld[c] | gc);
      drop[c] = hit & hold_vld[c] & ~gc;
    end
  end

  always_comb begin
    drop_sum = DSW'(drop_cnt_o);
    for (int c = 0; c < N; c++) begin
      drop_sum = drop_sum + DSW'(drop[c]);
    end
    drop_nxt = (drop_sum > DSW'(DROP_MAX)) ? DROP_MAX
                                           : drop_sum[DW-1:0];
  end

  assign gnt_entry = {gnt_idx, hold_pol[gnt_idx], hold_ts[gnt_idx]};

  always_ff @(posedge wb_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hold_vld   <= '0;
      hold_pol   <= '0;
      for (int c = 0; c < N; c++) hold_ts[c] <= '0;
      rr_ptr     <= '0;
      drop_cnt_o <= '0;
    end else if (flush_i) begin
      hold_vld   <= '0;
      rr_ptr     <= '0;
      drop_cnt_o <= '0;
    end else begin
      for (int c = 0; c < N; c++) begin
        if (load[c]) begin
          hold_vld[c] <= 1'b1;
          hold_pol[c] <= polarity_i[c];
          hold_ts[c]  <= ts_i[c*TSW +: TSW];
        end else if (gnt_vld && gnt_idx == CH_W'(c)) begin
          hold_vld[c] <= 1'b0;
        end
      end
      if (gnt_vld) begin
        rr_ptr <= (gnt_idx == LAST_CH) ? '0 : gnt_idx + 1'b1;
      end
      drop_cnt_o <= drop_nxt;
    end
  end

  tdc_evfifo #(
    .g_WIDTH (EW),
    .g_DEPTH (g_FIFO_DEPTH)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst_n (rst_n_i),
    .flush (flush_i),
    .push  (gnt_vld),
    .din   (gnt_entry),
    .pop   (rd_i),
    .dout  (rd_data_o),
    .level (level_o),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rd_valid_o = ~fifo_empty;
  assign irq_o      = (thresh_i != '0) && (level_o >= thresh_i);

endmodule

// File: tb/tb_tdc_event_arbiter.sv
// Self-checking bench for tdc_event_arbiter: queue-based event model
// plus directed literal checks and randomized traffic.
module tb_tdc_event_arbiter;

  localparam int N     = 2;
  localparam int TSW   = 38;
  localparam int DEPTH = 16;
  localparam int DW    = 4;
  localparam int CHW   = 1;
  localparam int LW    = 5;
  localparam int EW    = CHW + 1 + TSW;
  localparam int DMAX  = (1 << DW) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     en;
  logic [N-1:0]     det;
  logic [N-1:0]     pol;
  logic [N*TSW-1:0] ts;
  logic             flush;
  logic [LW-1:0]    thresh;
  logic             rd;
  logic             rd_valid;
  logic [EW-1:0]    rd_data;
  logic [LW-1:0]    level;
  logic             irq;
  logic [DW-1:0]    drop_cnt;

  int checks = 0;
  int errors = 0;

  bit             mv  [N];
  bit             mp  [N];
  logic [TSW-1:0] mts [N];
  logic [EW-1:0]  mq  [$];
  int             mrr;
  int             mdrop;

  always #5 clk = ~clk;

  tdc_event_arbiter #(
    .g_CHANNEL_COUNT (N),
    .g_TS_WIDTH      (TSW),
    .g_FIFO_DEPTH    (DEPTH),
    .g_DROP_WIDTH    (DW)
  ) dut (
    .wb_clk_i   (clk),
    .rst_n_i    (rst_n),
    .enable_i   (en),
    .detect_i   (det),
    .polarity_i (pol),
    .ts_i       (ts),
    .flush_i    (flush),
    .thresh_i   (thresh),
    .rd_i       (rd),
    .rd_valid_o (rd_valid),
    .rd_data_o  (rd_data),
    .level_o    (level),
    .irq_o      (irq),
    .drop_cnt_o (drop_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N; c++) mv[c] = 1'b0;
    mq.delete();
    mrr   = 0;
    mdrop = 0;
  endtask

  task automatic model_step();
    bit pop_ok;
    int g;
    int nd;
    logic [CHW-1:0] gc;
    if (flush) begin
      model_reset();
      return;
    end
    pop_ok = rd && (mq.size() > 0);
    g = -1;
    nd = 0;
    if (mq.size() < DEPTH || pop_ok) begin
      for (int i = 0; i < N; i++) begin
        int k;
        k = (mrr + i) % N;
        if (g < 0 && mv[k]) g = k;
      end
    end
    if (pop_ok) void'(mq.pop_front());
    if (g >= 0) begin
      gc = g[CHW-1:0];
      mq.push_back({gc, mp[g], mts[g]});
      mv[g] = 1'b0;
      mrr = (g + 1) % N;
    end
    for (int c = 0; c < N; c++) begin
      if (det[c] && en[c]) begin
        if (!mv[c]) begin
          mv[c]  = 1'b1;
          mp[c]  = pol[c];
          mts[c] = ts[c*TSW +: TSW];
        end else begin
          nd++;
        end
      end
    end
    mdrop = (mdrop + nd > DMAX) ? DMAX : mdrop + nd;
  endtask

  task automatic compare();
    logic [EW-1:0] eh;
    int lvl;
    lvl = mq.size();
    eh = (lvl > 0) ? mq[0] : '0;
    chk("rd_valid", 64'(rd_valid), 64'(lvl > 0));
    chk("rd_data", 64'(rd_data), 64'(eh));
    chk("level", 64'(level), 64'(lvl));
    chk("irq", 64'(irq), 64'((thresh != 0) && (lvl >= int'(thresh))));
    chk("drop_cnt", 64'(drop_cnt), 64'(mdrop));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic idle();
    det   = '0;
    rd    = 1'b0;
    flush = 1'b0;
  endtask

  task automatic do_flush();
    idle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
  endtask

  initial begin
    logic [EW-1:0] e123;
    e123   = {1'b0, 1'b1, 38'h123};
    rst_n  = 1'b0;
    en     = '0;
    pol    = '0;
    ts     = '0;
    thresh = '0;
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    compare();
    chk("reset_level", 64'(level), 64'd0);
    chk("reset_valid", 64'(rd_valid), 64'd0);

    // single event, two-cycle latency
    en = 2'b11;
    det = 2'b01;
    pol = 2'b01;
    ts[TSW-1:0] = 38'h123;
    cycle();
    idle();
    chk("single_t1_valid", 64'(rd_valid), 64'd0);
    cycle();
    chk("single_valid", 64'(rd_valid), 64'd1);
    chk("single_data", 64'(rd_data), 64'(e123));
    chk("single_level", 64'(level), 64'd1);
    rd = 1'b1;
    cycle();
    rd = 1'b0;
    chk("single_pop_level", 64'(level), 64'd0);
    chk("single_pop_data", 64'(rd_data), 64'd0);

    // simultaneous detects from rr_ptr=0
    do_flush();
    det = 2'b11;
    cycle();
    idle();
    cycle();
    cycle();
    chk("simul_first_ch", 64'(rd_data[EW-1]), 64'd0);
    rd = 1'b1;
    cycle();
    rd = 1'b0;
    chk("simul_second_ch", 64'(rd_data[EW-1]), 64'd1);

    // rotation: ch0 granted, then contention starts at ch1
    do_flush();
    det = 2'b01;
    cycle();
    det = 2'b11;
    cycle();
    idle();
    cycle();
    cycle();
    chk("rot_level", 64'(level), 64'd3);
    for (int i = 0; i < 3; i++) begin
      chk("rot_order", 64'(rd_data[EW-1]), 64'((i == 1) ? 1 : 0));
      rd = 1'b1;
      cycle();
    end
    rd = 1'b0;

    // fill, irq, overflow and drops on ch0
    do_flush();
    thresh = LW'(8);
    det = 2'b01;
    for (int i = 1; i <= 20; i++) begin
      ts = {$urandom(), $urandom(), $urandom()};
      cycle();
      if (i == 8)  chk("fill_irq_low", 64'(irq), 64'd0);
      if (i == 9)  chk("fill_irq_high", 64'(irq), 64'd1);
    end
    chk("fill_level_sat", 64'(level), 64'd16);
    chk("fill_drops", 64'(drop_cnt), 64'd3);
    rd = 1'b1;
    cycle();
    rd = 1'b0;
    chk("full_pop_level", 64'(level), 64'd16);
    chk("full_pop_drops", 64'(drop_cnt), 64'd3);
    repeat (20) cycle();
    chk("drop_saturate", 64'(drop_cnt), 64'(DMAX));
    repeat (3) cycle();
    chk("drop_stays_max", 64'(drop_cnt), 64'(DMAX));
    thresh = '0;
    cycle();
    chk("thresh0_irq", 64'(irq), 64'd0);

    // disabled channels and empty pop
    do_flush();
    en = 2'b00;
    det = 2'b11;
    repeat (5) cycle();
    chk("disabled_level", 64'(level), 64'd0);
    chk("disabled_drop", 64'(drop_cnt), 64'd0);
    idle();
    rd = 1'b1;
    cycle();
    rd = 1'b0;
    chk("empty_pop_valid", 64'(rd_valid), 64'd0);
    chk("empty_pop_level", 64'(level), 64'd0);

    // flush mid-stream beats detect and pop
    en = 2'b11;
    det = 2'b01;
    repeat (6) cycle();
    chk("pre_flush_level", 64'(level), 64'd5);
    det = 2'b11;
    rd = 1'b1;
    flush = 1'b1;
    cycle();
    chk("flush_level", 64'(level), 64'd0);
    chk("flush_valid", 64'(rd_valid), 64'd0);
    chk("flush_drop", 64'(drop_cnt), 64'd0);
    idle();
    cycle();
    chk("flush_discard", 64'(level), 64'd0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      en    = ($urandom_range(0, 7) == 0) ? N'($urandom()) : 2'b11;
      det   = N'($urandom());
      pol   = N'($urandom());
      ts    = {$urandom(), $urandom(), $urandom()};
      rd    = ((i / 400) % 2 == 0) ? ($urandom_range(0, 3) == 0)
                                   : ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 49) == 0) thresh = LW'($urandom_range(0, 16));
      cycle();
    end

    // asynchronous reset mid-burst
    idle();
    en = 2'b11;
    det = 2'b11;
    repeat (4) cycle();
    chk("pre_reset_level", 64'(level != 0), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_valid", 64'(rd_valid), 64'd0);
    chk("rst_data", 64'(rd_data), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    compare();
    det = 2'b10;
    pol = 2'b00;
    ts  = '0;
    ts[TSW +: TSW] = 38'h55;
    cycle();
    idle();
    chk("post_rst_t1", 64'(rd_valid), 64'd0);
    cycle();
    chk("post_rst_valid", 64'(rd_valid), 64'd1);
    chk("post_rst_data", 64'(rd_data), 64'({1'b1, 1'b0, 38'h55}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
